// File: rtl/vend_txn_ctrl.sv
// Vending transaction controller: touch-key handling, credit accumulation, product
// selection/purchase against a live price table, vend handshake and greedy change return.
module vend_txn_ctrl #(
  parameter int N_PROD      = 12,
  parameter int PW          = 8,
  parameter int CREDIT_W    = 11,
  parameter int CREDIT_MAX  = 1999,
  parameter int KEY_W       = 5,
  parameter int PID_W       = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 touch_valid,
  input  logic [KEY_W-1:0]     touch_key,
  input  logic [N_PROD*PW-1:0] price_tbl,
  output logic                 vend_valid,
  output logic [PID_W-1:0]     vend_id,
  input  logic                 vend_ready,
  output logic                 chg_valid,
  output logic [1:0]           chg_coin,
  input  logic                 chg_ready,
  output logic [CREDIT_W-1:0]  credit,
  output logic [PID_W-1:0]     sel_id,
  output logic [1:0]           state,
  output logic                 coin_acc,
  output logic                 coin_rej,
  output logic                 nonenough,
  output logic                 soldout
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEL = 2'd1, S_VEND = 2'd2, S_CHANGE = 2'd3} state_t;

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [KEY_W-1:0] K_SURE   = KEY_W'(N_PROD + 1);
  localparam logic [KEY_W-1:0] K_CANCEL = KEY_W'(N_PROD + 2);
  localparam logic [KEY_W-1:0] K_C05    = KEY_W'(N_PROD + 3);
  localparam logic [KEY_W-1:0] K_C1     = KEY_W'(N_PROD + 4);
  localparam logic [KEY_W-1:0] K_C5     = KEY_W'(N_PROD + 5);
  localparam logic [KEY_W-1:0] K_C10    = KEY_W'(N_PROD + 6);
  localparam logic [KEY_W-1:0] K_REFUND = KEY_W'(N_PROD + 7);

  function automatic logic [PW-1:0] price_of(input logic [N_PROD*PW-1:0] tbl, input int p);
    if (p >= 1 && p <= N_PROD) return tbl[(p-1)*PW +: PW];
    return '0;
  endfunction

  function automatic logic [CREDIT_W:0] coin_val(input logic [KEY_W-1:0] k);
    case (k)
      K_C05:   return (CREDIT_W+1)'(1);
      K_C1:    return (CREDIT_W+1)'(2);
      K_C5:    return (CREDIT_W+1)'(10);
      K_C10:   return (CREDIT_W+1)'(20);
      default: return '0;
    endcase
  endfunction

  function automatic logic [CREDIT_W-1:0] denom_val(input logic [1:0] idx);
    case (idx)
      2'd0:    return CREDIT_W'(1);
      2'd1:    return CREDIT_W'(2);
      2'd2:    return CREDIT_W'(10);
      default: return CREDIT_W'(20);
    endcase
  endfunction

  // Largest coin not exceeding the remaining credit.
  function automatic logic [1:0] greedy(input logic [CREDIT_W-1:0] c);
    if (c >= CREDIT_W'(20)) return 2'd3;
    if (c >= CREDIT_W'(10)) return 2'd2;
    if (c >= CREDIT_W'(2))  return 2'd1;
    return 2'd0;
  endfunction

  state_t              st;
  logic                tv_q;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                key_evt;
  logic                is_prod;
  logic                is_coin;
  logic                coin_ok;
  logic                tmo_hit;
  logic [PW-1:0]       key_price;
  logic [PW-1:0]       sel_price;
  logic [CREDIT_W:0]   coin_sum;
  logic [CREDIT_W-1:0] chg_rem;
  logic [PID_W-1:0]    key_pid;

  assign state = st;

  always_comb begin
    key_evt   = touch_valid & ~tv_q;
    key_pid   = touch_key[PID_W-1:0];
    is_prod   = (touch_key != '0) && (touch_key <= KEY_W'(N_PROD));
    is_coin   = (touch_key >= K_C05) && (touch_key <= K_C10);
    key_price = price_of(price_tbl, int'(touch_key));
    sel_price = price_of(price_tbl, int'(sel_id));
    // One bit wider than credit so the overflow check cannot wrap.
    coin_sum  = {1'b0, credit} + coin_val(touch_key);
    coin_ok   = coin_sum <= (CREDIT_W+1)'(CREDIT_MAX);
    chg_rem   = credit - denom_val(chg_coin);
    tmo_hit   = tmo_cnt == TMO_W'(TIMEOUT_CYC - 1);
  end

  // NOTE: every register here, including the single-cycle pulses, is assigned with <=
  // so all decisions in a cycle see the pre-edge state; pulses default low each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= S_IDLE;
      tv_q       <= 1'b0;
      tmo_cnt    <= '0;
      credit     <= '0;
      sel_id     <= '0;
      vend_id    <= '0;
      vend_valid <= 1'b0;
      chg_valid  <= 1'b0;
      chg_coin   <= '0;
      coin_acc   <= 1'b0;
      coin_rej   <= 1'b0;
      nonenough  <= 1'b0;
      soldout    <= 1'b0;
    end else begin
      tv_q      <= touch_valid;
      coin_acc  <= 1'b0;
      coin_rej  <= 1'b0;
      nonenough <= 1'b0;
      soldout   <= 1'b0;
      tmo_cnt   <= (st == S_IDLE || st == S_SEL) ? tmo_cnt + TMO_W'(1) : '0;

      case (st)
        S_IDLE, S_SEL: begin
          if (key_evt) begin
            tmo_cnt <= '0;
            if (is_coin) begin
              if (coin_ok) begin
                credit   <= coin_sum[CREDIT_W-1:0];
                coin_acc <= 1'b1;
              end else begin
                coin_rej <= 1'b1;
              end
            end else if (is_prod) begin
              if (key_price != '0) begin
                sel_id <= key_pid;
                st     <= S_SEL;
              end else begin
                soldout <= 1'b1;
              end
            end else if (touch_key == K_CANCEL) begin
              sel_id <= '0;
              st     <= S_IDLE;
            end else if (touch_key == K_REFUND) begin
              sel_id <= '0;
              if (credit != '0) begin
                st        <= S_CHANGE;
                chg_valid <= 1'b1;
                chg_coin  <= greedy(credit);
              end else begin
                st <= S_IDLE;
              end
            end else if (touch_key == K_SURE && st == S_SEL) begin
              if (credit >= CREDIT_W'(sel_price)) begin
                credit     <= credit - CREDIT_W'(sel_price);
                vend_id    <= sel_id;
                sel_id     <= '0;
                vend_valid <= 1'b1;
                st         <= S_VEND;
              end else begin
                nonenough <= 1'b1;
              end
            end
          end else if (tmo_hit) begin
            tmo_cnt <= '0;
            if (st == S_SEL) begin
              sel_id <= '0;
              st     <= S_IDLE;
            end else if (credit != '0) begin
              st        <= S_CHANGE;
              chg_valid <= 1'b1;
              chg_coin  <= greedy(credit);
            end
          end
        end

        S_VEND: begin
          if (vend_ready) begin
            vend_valid <= 1'b0;
            st         <= S_IDLE;
          end
        end

        S_CHANGE: begin
          if (chg_ready) begin
            credit <= chg_rem;
            if (chg_rem == '0) begin
              chg_valid <= 1'b0;
              st        <= S_IDLE;
            end else begin
              chg_coin <= greedy(chg_rem);
            end
          end
        end

        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Directed bench for vend_txn_ctrl: key-event vector table plus hand-written
// vend, change, overflow, timeout and reset sequences.
module tb_vend_txn_ctrl;

  localparam int N_PROD = 12;
  localparam int PW     = 8;

  // pulse codes in the vector table
  localparam int P_NONE = 0, P_ACC = 1, P_REJ = 2, P_NE = 3, P_SO = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 touch_valid = 1'b0;
  logic [4:0]           touch_key = '0;
  logic [N_PROD*PW-1:0] price_tbl = '0;
  logic                 vend_valid;
  logic [3:0]           vend_id;
  logic                 vend_ready = 1'b0;
  logic                 chg_valid;
  logic [1:0]           chg_coin;
  logic                 chg_ready = 1'b0;
  logic [10:0]          credit;
  logic [3:0]           sel_id;
  logic [1:0]           state;
  logic                 coin_acc, coin_rej, nonenough, soldout;

  vend_txn_ctrl #(.TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst), .touch_valid(touch_valid), .touch_key(touch_key),
    .price_tbl(price_tbl), .vend_valid(vend_valid), .vend_id(vend_id),
    .vend_ready(vend_ready), .chg_valid(chg_valid), .chg_coin(chg_coin),
    .chg_ready(chg_ready), .credit(credit), .sel_id(sel_id), .state(state),
    .coin_acc(coin_acc), .coin_rej(coin_rej), .nonenough(nonenough), .soldout(soldout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] key;
    int         exp_credit;
    int         exp_state;
    int         exp_sel;
    int         exp_pulse;
  } vec_t;

  vec_t vecs[24];
  int   n_vec = 0;
  int   n_bad = 0;
  int   acc_n = 0, rej_n = 0, ne_n = 0, so_n = 0;
  int   coins[$];

  always @(negedge clk) begin
    if (coin_acc)  acc_n++;
    if (coin_rej)  rej_n++;
    if (nonenough) ne_n++;
    if (soldout)   so_n++;
    if (chg_valid && chg_ready) coins.push_back(int'(chg_coin));
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic [4:0] k);
    @(negedge clk);
    touch_valid = 1'b1;
    touch_key   = k;
    repeat (3) @(negedge clk);
    touch_valid = 1'b0;
    touch_key   = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_state(input int s, input int limit, input string name);
    int n = 0;
    while (int'(state) != s && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(state), s);
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      int a0 = acc_n, r0 = rej_n, n0 = ne_n, s0 = so_n;
      int got_p, exp_p;
      press(vecs[i].key);
      got_p = (so_n - s0) * 1000 + (ne_n - n0) * 100 + (rej_n - r0) * 10 + (acc_n - a0);
      case (vecs[i].exp_pulse)
        P_ACC:   exp_p = 1;
        P_REJ:   exp_p = 10;
        P_NE:    exp_p = 100;
        P_SO:    exp_p = 1000;
        default: exp_p = 0;
      endcase
      check($sformatf("v%0d credit", i), int'(credit), vecs[i].exp_credit);
      check($sformatf("v%0d state", i), int'(state), vecs[i].exp_state);
      check($sformatf("v%0d sel_id", i), int'(sel_id), vecs[i].exp_sel);
      check($sformatf("v%0d pulses", i), got_p, exp_p);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    // key codes: 13 sure, 14 cancel, 15/16/17/18 coins 0.5/1/5/10, 19 refund
    vecs[0]  = '{5'd18,   20, 0, 0, P_ACC};
    vecs[1]  = '{5'd18,   40, 0, 0, P_ACC};
    vecs[2]  = '{5'd15,   41, 0, 0, P_ACC};
    vecs[3]  = '{5'd3,    41, 0, 0, P_SO};
    vecs[4]  = '{5'd2,    41, 1, 2, P_NONE};
    vecs[5]  = '{5'd3,    41, 1, 2, P_SO};
    vecs[6]  = '{5'd6,    41, 1, 6, P_NONE};
    vecs[7]  = '{5'd14,   41, 0, 0, P_NONE};
    vecs[8]  = '{5'd13,   41, 0, 0, P_NONE};
    vecs[9]  = '{5'd6,    41, 1, 6, P_NONE};
    vecs[10] = '{5'd18, 1990, 0, 0, P_REJ};
    vecs[11] = '{5'd15, 1991, 0, 0, P_ACC};
    vecs[12] = '{5'd17, 1991, 0, 0, P_REJ};
    vecs[13] = '{5'd16, 1993, 0, 0, P_ACC};
    vecs[14] = '{5'd16, 1995, 0, 0, P_ACC};
    vecs[15] = '{5'd16, 1997, 0, 0, P_ACC};
    vecs[16] = '{5'd16, 1999, 0, 0, P_ACC};
    vecs[17] = '{5'd15, 1999, 0, 0, P_REJ};
    vecs[18] = '{5'd2,     0, 1, 2, P_NONE};
    vecs[19] = '{5'd19,    0, 0, 0, P_NONE};
    vecs[20] = '{5'd16,    2, 0, 0, P_ACC};
    vecs[21] = '{5'd16,    4, 0, 0, P_ACC};
    vecs[22] = '{5'd2,     4, 1, 2, P_NONE};
    vecs[23] = '{5'd13,    4, 1, 2, P_NE};

    for (int p = 1; p <= N_PROD; p++) price_tbl[(p-1)*PW +: PW] = 8'(p * 2 + 10);
    price_tbl[1*PW +: PW] = 8'd16;  // product 2
    price_tbl[2*PW +: PW] = 8'd0;   // product 3 sold out
    price_tbl[5*PW +: PW] = 8'd24;  // product 6

    repeat (3) @(negedge clk);
    check("rst credit", int'(credit), 0);
    check("rst state", int'(state), 0);
    check("rst sel_id", int'(sel_id), 0);
    check("rst vend_valid", int'(vend_valid), 0);
    check("rst chg_valid", int'(chg_valid), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    apply_vecs(0, 9);

    // purchase product 6 with a dispenser that stalls for 5 cycles
    press(5'd13);
    check("vend state", int'(state), 2);
    check("vend valid", int'(vend_valid), 1);
    check("vend id", int'(vend_id), 6);
    check("vend credit", int'(credit), 17);
    repeat (5) @(negedge clk);
    check("vend held", int'(vend_valid), 1);
    check("vend id held", int'(vend_id), 6);
    vend_ready = 1'b1;
    @(negedge clk);
    vend_ready = 1'b0;
    check("vend drop", int'(vend_valid), 0);
    check("vend idle", int'(state), 0);
    check("vend keep credit", int'(credit), 17);

    // refund 17 with coin return always ready: 10,2,2,2,1
    coins.delete();
    chg_ready = 1'b1;
    press(5'd19);
    wait_state(0, 50, "refund done");
    chg_ready = 1'b0;
    check("refund ncoins", coins.size(), 5);
    if (coins.size() == 5) begin
      check("refund c0", coins[0], 2);
      check("refund c1", coins[1], 1);
      check("refund c2", coins[2], 1);
      check("refund c3", coins[3], 1);
      check("refund c4", coins[4], 0);
    end
    check("refund credit", int'(credit), 0);
    check("refund chg_valid", int'(chg_valid), 0);

    // climb to 1990 then probe the credit ceiling
    for (int i = 0; i < 99; i++) press(5'd18);
    press(5'd17);
    check("fill credit", int'(credit), 1990);
    apply_vecs(10, 17);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst2 credit", int'(credit), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    apply_vecs(18, 23);

    // SEL times out back to IDLE, then IDLE with credit times out into change
    repeat (85) @(negedge clk);
    check("tmo not early", int'(state), 1);
    wait_state(0, 40, "tmo sel->idle");
    check("tmo sel_id", int'(sel_id), 0);
    repeat (90) @(negedge clk);
    check("tmo idle wait", int'(state), 0);
    wait_state(3, 30, "tmo idle->change");
    check("tmo chg_valid", int'(chg_valid), 1);
    check("tmo chg_coin", int'(chg_coin), 1);
    check("tmo credit", int'(credit), 4);
    repeat (3) @(negedge clk);
    check("stall chg_coin", int'(chg_coin), 1);
    check("stall chg_valid", int'(chg_valid), 1);
    coins.delete();
    chg_ready = 1'b1;
    wait_state(0, 20, "tmo change done");
    chg_ready = 1'b0;
    check("tmo ncoins", coins.size(), 2);
    if (coins.size() == 2) begin
      check("tmo c0", coins[0], 1);
      check("tmo c1", coins[1], 1);
    end
    check("tmo final credit", int'(credit), 0);

    // reset in the middle of a vend discards everything
    press(5'd18);
    press(5'd2);
    press(5'd13);
    check("rv state", int'(state), 2);
    check("rv credit", int'(credit), 4);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rv vend_valid", int'(vend_valid), 0);
    check("rv credit0", int'(credit), 0);
    check("rv state0", int'(state), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rv no request", int'(vend_valid), 0);
    check("rv still idle", int'(state), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
